multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Moore-style state machine that sequences the processor's shared datapath over several cycles per instruction. It fetches each instruction through a ready-based handshake and classifies it from the instruction-register fields. It then steps through execute, memory and writeback, driving the register-file, data-memory and PC/IR write strobes. The instruction decoder remains combinational; this block supplies only the per-cycle enables, the memory handshakes, error detection and retired-instruction counting.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles to wait for a memory ready before halting; 0 disables the timeout.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 7: IR[6:0], valid from the cycle after `ir_we`.
- `funct3` in 3: IR[14:12].
- `funct7` in 7: IR[31:25]; used only for legality checking.
- `imem_ready` in 1: instruction memory has the data for this cycle.
- `dmem_ready` in 1: data-memory access completes this cycle.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data-memory request.
- `DMWR` out 1: data-memory write strobe.
- `DMCtrl` out 3: access size/sign, the latched `funct3`.
- `ir_we` out 1: load the IR.
- `pc_we` out 1: PC <= PC+4.
- `RUWr` out 1: register-file write enable.
- `state` out 3: current state encoding.
- `halted` out 1: sticky halt flag.
- `err_code` out 2: 00 none, 01 illegal instruction, 10 imem timeout, 11 dmem timeout.
- `instret` out 32: count of retired instructions.

## Operation
- State encodings:
  - START = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, MEM = 4, WB = 5, HALT = 6.
  - Encoding 7 is unreachable; if entered, go to HALT with `err_code` = 01.
- Reset (asynchronous, takes effect immediately) forces:
  - `state` = START.
  - `instret` = 0, `err_code` = 00, `halted` = 0.
  - Class latch = ILLEGAL, `DMCtrl` latch = 000, timeout counter = 0.
- Outputs are decoded from the state. During reset and in START, every strobe (`imem_req`, `dmem_req`, `DMWR`, `ir_we`, `pc_we`, `RUWr`) is 0.
- START: the state after reset. Go to FETCH on the next edge.
- FETCH:
  - `imem_req` = 1.
  - When `imem_ready` = 1, assert `ir_we` = 1 and `pc_we` = 1 in that same cycle, then go to DECODE.
- DECODE: sample `opcode`/`funct3`/`funct7` and latch the class:
  - 0110011 → RTYPE. Legal only if `funct7` = 0000000, or `funct7` = 0100000 with `funct3` ∈ {000, 101}.
  - 0010011 → ITYPE.
  - 0000011 → LOAD. Legal only if `funct3` ∈ {000, 001, 010, 100, 101}.
  - 0100011 → STORE. Legal only if `funct3` ∈ {000, 001, 010}.
  - Anything else, or an illegal combination → HALT, `err_code` = 01.
  - Latch `DMCtrl` <= `funct3`.
- EXECUTE: the ALU settles here. RTYPE/ITYPE → WB; LOAD/STORE → MEM.
- MEM:
  - `dmem_req` = 1; `DMWR` = 1 only for STORE.
  - On `dmem_ready` = 1: a LOAD goes to WB; a STORE goes to FETCH and increments `instret`.
- WB: `RUWr` = 1 for exactly one cycle, `instret` += 1, go to FETCH.
- HALT:
  - All strobes 0, `halted` = 1.
  - Remains in HALT until reset; `err_code` is held.
- Timeout counter:
  - Cleared on entry to FETCH or MEM.
  - Increments on each FETCH/MEM cycle in which ready is 0.
  - If the counter equals `TIMEOUT` and ready is still 0, go to HALT with `err_code` 10 (from FETCH) or 11 (from MEM).
  - If ready and the timeout condition occur in the same cycle, ready wins.
  - `TIMEOUT` = 0 disables the timeout entirely.
- `instret` wraps from 0xFFFFFFFF to 0 without any flag.

## Timing
- Ready signals are sampled at the rising edge; each handshake completes in the cycle where request and ready are both 1.
- With zero-wait memories, the number of cycles from FETCH entry back to FETCH entry is:
  - R-type and I-type: 4 (FETCH, DECODE, EXECUTE, WB).
  - Load: 5.
  - Store: 4.
- Each wait cycle on a ready signal adds one cycle.
- The first `imem_req` occurs in the second cycle after `rst` falls.
- `instret` is updated on the edge that leaves WB, or the edge that leaves MEM for a store.
- `RUWr` and `DMWR` are never both 1.
- `ir_we` is only ever 1 in FETCH.
- Reset asserted in MEM drops `dmem_req`/`DMWR` combinationally, before the next edge.

## Test plan
- Reset, then R-type add (0110011/000/0000000) with `imem_ready` tied to 1 → states 0,1,2,3,5,1; `RUWr` high for 1 cycle; `instret` = 1.
- Load `lw` (funct3 = 010) with `dmem_ready` delayed 3 cycles → MEM held for 4 cycles; `DMCtrl` = 010, `DMWR` = 0; `RUWr` pulses in WB; total 8 cycles.
- Store `sb` (funct3 = 000) with `dmem_ready` = 1 → `DMWR` = 1 for 1 cycle in MEM; `RUWr` never asserted; back to FETCH; `instret` += 1.
- Opcode 1111111, and separately R-type with `funct7` = 0100000, `funct3` = 001 → HALT; `err_code` = 01; `halted` = 1; all strobes 0 until reset.
- `TIMEOUT` = 4, `imem_ready` held at 0 → HALT after the 5th FETCH cycle, `err_code` = 10. Repeat with `dmem_ready` rising exactly on the 5th MEM cycle → no halt.
- Assert reset mid-MEM of a store → `DMWR`/`dmem_req` fall immediately; `state` = 0; `instret` = 0; after release, FETCH begins normally.

Source files
------------

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multi-cycle control FSM that sequences fetch, decode, execute,
//               memory and writeback, with memory time-outs and a retire count.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        DMWR,
  output logic [2:0]  DMCtrl,
  output logic        ir_we,
  output logic        pc_we,
  output logic        RUWr,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL = 3'd0,
    CL_RTYPE   = 3'd1,
    CL_ITYPE   = 3'd2,
    CL_LOAD    = 3'd3,
    CL_STORE   = 3'd4
  } class_t;

  localparam logic [1:0] c_err_none    = 2'b00;
  localparam logic [1:0] c_err_illegal = 2'b01;
  localparam logic [1:0] c_err_imem    = 2'b10;
  localparam logic [1:0] c_err_dmem    = 2'b11;

  localparam int unsigned c_tmo_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_lim = c_tmo_w'(TIMEOUT);

  state_t             state_q, state_d;
  class_t             class_q, class_d;
  logic [2:0]         dmctrl_q, dmctrl_d;
  logic [c_tmo_w-1:0] tmo_q, tmo_d;
  logic [31:0]        instret_q, instret_d;
  logic [1:0]         err_q, err_d;
  logic               halted_q, halted_d;

  class_t             dec_class;
  logic               tmo_hit;

  // Instruction classification, including the legality of each field combination.
  always_comb begin
    dec_class = CL_ILLEGAL;
    case (opcode)
      7'b0110011: begin
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))))
          dec_class = CL_RTYPE;
      end
      7'b0010011: dec_class = CL_ITYPE;
      7'b0000011: begin
        if ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
            (funct3 == 3'b100) || (funct3 == 3'b101))
          dec_class = CL_LOAD;
      end
      7'b0100011: begin
        if ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010))
          dec_class = CL_STORE;
      end
      default: dec_class = CL_ILLEGAL;
    endcase
  end

  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == c_tmo_lim);

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    dmctrl_d  = dmctrl_q;
    tmo_d     = '0;
    instret_d = instret_q;
    err_d     = err_q;
    halted_d  = halted_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    DMWR      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    RUWr      = 1'b0;

    case (state_q)
      ST_START: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_hit) begin
          state_d = ST_HALT;
          err_d   = c_err_imem;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_DECODE: begin
        class_d  = dec_class;
        dmctrl_d = funct3;
        if (dec_class == CL_ILLEGAL) begin
          state_d = ST_HALT;
          err_d   = c_err_illegal;
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        case (class_q)
          CL_RTYPE, CL_ITYPE: state_d = ST_WB;
          CL_LOAD, CL_STORE:  state_d = ST_MEM;
          default: begin
            state_d = ST_HALT;
            err_d   = c_err_illegal;
          end
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        DMWR     = (class_q == CL_STORE);
        if (dmem_ready) begin
          // Stores retire straight out of MEM; loads still need a writeback.
          if (class_q == CL_STORE) begin
            state_d   = ST_FETCH;
            instret_d = instret_q + 32'd1;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_hit) begin
          state_d = ST_HALT;
          err_d   = c_err_dmem;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_WB: begin
        RUWr      = 1'b1;
        instret_d = instret_q + 32'd1;
        state_d   = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: begin
        state_d = ST_HALT;
        err_d   = c_err_illegal;
      end
    endcase

    if (state_d == ST_HALT)
      halted_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_START;
      class_q   <= CL_ILLEGAL;
      dmctrl_q  <= 3'b000;
      tmo_q     <= '0;
      instret_q <= 32'd0;
      err_q     <= c_err_none;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      dmctrl_q  <= dmctrl_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
      err_q     <= err_d;
      halted_q  <= halted_d;
    end
  end

  assign state    = state_q;
  assign DMCtrl   = dmctrl_q;
  assign halted   = halted_q;
  assign err_code = err_q;
  assign instret  = instret_q;

endmodule
`default_nettype wire
